// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : encodes instruction requests into 32-bit words and writes
//                 them sequentially into an instruction memory.
// Revision      : 1.0
// ============================================================================
module instr_encoder #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [4:0]       in_rs,
   input  logic [4:0]       in_rt,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_shamt,
   input  logic [25:0]      in_imm,
   input  logic             in_last,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             done,
   output logic             err,
   output logic [AW:0]      count
);

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      WRITE  = 2'd1,
      FULL   = 2'd2
   } state_t;

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             last_q, last_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             err_q, err_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] enc_word;
   logic             op_illegal;

   always_comb begin
      enc_word   = '0;
      op_illegal = 1'b0;
      case (in_op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4:
            enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, {2'b00, in_op}};
         4'd5:    enc_word = {6'd4, in_rs, in_rt, in_imm[15:0]};
         4'd6:    enc_word = {6'd5, in_rs, in_rt, in_imm[15:0]};
         4'd7:    enc_word = {6'd6, in_rs, in_rt, in_imm[15:0]};
         4'd8:    enc_word = {6'd2, in_imm};
         4'd9:    enc_word = {6'd3, in_imm};
         default: op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      last_d   = last_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      done_d   = 1'b0;
      case (state_q)
         ACCEPT: begin
            if (in_valid) begin
               if (op_illegal) begin
                  err_d = 1'b1;
               end else begin
                  word_d  = enc_word;
                  last_d  = in_last;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (last_q) begin
               done_d   = 1'b1;
               wr_ptr_d = '0;
               count_d  = '0;
               state_d  = ACCEPT;
            end else begin
               count_d = count_q + CNT_ONE;
               // Pointer parks on the last word in FULL instead of wrapping
               if (wr_ptr_q == PTR_LAST) begin
                  state_d = FULL;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  state_d  = ACCEPT;
               end
            end
         end
         FULL:    state_d = FULL;
         default: state_d = ACCEPT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ACCEPT;
         word_q   <= '0;
         last_q   <= 1'b0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         last_q   <= last_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign in_ready  = (state_q == ACCEPT);
   assign mem_we    = (state_q == WRITE);
   assign mem_addr  = wr_ptr_q;
   assign mem_wdata = word_q;
   assign done      = done_q;
   assign err       = err_q;
   assign count     = count_q;

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the instruction word width; only 32 is supported.
REQ-002 The module SHALL have parameter DEPTH, default 64, meaning the number of instruction-memory words; AW = clog2(DEPTH).
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, meaning the synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit, meaning an instruction request is present.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the encoder accepts a request this cycle.
REQ-007 The module SHALL have port in_op, input, 4 bits, meaning the operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 J, 9 JAL, 10-15 illegal.
REQ-008 The module SHALL have ports in_rs, in_rt, in_rd and in_shamt, each input, 5 bits, meaning the register and shift fields.
REQ-009 The module SHALL have port in_imm, input, 26 bits, meaning the immediate (I-type uses [15:0]) or the jump target (J-type uses [25:0]).
REQ-010 The module SHALL have port in_last, input, 1 bit, meaning this is the final instruction of a program.
REQ-011 The module SHALL have port mem_we, output, 1 bit, meaning the instruction-memory write enable.
REQ-012 The module SHALL have port mem_addr, output, AW bits, meaning the word address being written.
REQ-013 The module SHALL have port mem_wdata, output, 32 bits, meaning the encoded instruction word.
REQ-014 The module SHALL have port done, output, 1 bit, meaning a one-cycle pulse when a program completes.
REQ-015 The module SHALL have port err, output, 1 bit, meaning a sticky illegal-op flag.
REQ-016 The module SHALL have port count, output, AW+1 bits, meaning the number of words written in the current program.

Function
REQ-017 Encoding SHALL be as follows.
- R-type (ops 0-4): {6'b000000, rs, rt, rd, shamt, funct}, with funct = 6'(in_op), i.e. ADD 0, SUB 1, AND 2, OR 3, SLT 4.
- LW, SW, BEQ: {opcode, rs, rt, imm[15:0]}, with opcode LW 6'd4, SW 6'd5, BEQ 6'd6.
- J and JAL: {opcode, imm[25:0]}, with opcode J 6'd2, JAL 6'd3.
- Unused input fields SHALL be ignored.
REQ-018 The FSM SHALL have states ACCEPT, WRITE and FULL; in_ready SHALL be 1 only in ACCEPT and SHALL NOT depend combinationally on in_valid.
REQ-019 In ACCEPT, on in_valid&in_ready with a legal op, the module SHALL register the encoded word and in_last, then go to WRITE.
REQ-020 In ACCEPT, on in_valid&in_ready with an illegal op, the module SHALL set err, write nothing, leave wr_ptr and count unchanged, and remain in ACCEPT.
REQ-021 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=wr_ptr and mem_wdata=the registered word; outside WRITE, mem_we SHALL be 0.
REQ-022 Latency SHALL be one cycle (handshake at cycle N gives mem_we at N+1); maximum throughput SHALL be one instruction per 2 cycles.
REQ-023 On leaving WRITE with the registered last=0, the module SHALL do wr_ptr+=1 and count+=1.
- If wr_ptr was DEPTH-1, the next state SHALL be FULL.
- Otherwise the next state SHALL be ACCEPT.
REQ-024 On leaving WRITE with the registered last=1, the module SHALL assert done for one cycle (the cycle after WRITE), reset wr_ptr and count to 0, and return to ACCEPT; last=1 SHALL take priority over the full condition.
REQ-025 FULL SHALL hold in_ready=0 and count=DEPTH until reset; this is the overflow case, with no wrap-around write.
REQ-026 wr_ptr SHALL never wrap silently.
REQ-027 err SHALL clear only on reset; done and mem_we SHALL never be asserted in the same cycle.

Reset
REQ-028 With reset=1 at a clock edge, the module SHALL set state=ACCEPT, wr_ptr=0, count=0, err=0, done=0 and mem_we=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-029 A reset during WRITE SHALL suppress that write in the following cycle and discard the registered word; reset SHALL override all other events.

Verification
REQ-030 Legal R-type and I-type encodes from reset:
- ADD rs=1 rt=2 rd=3 -> mem_we at N+1, addr 0, wdata 0x00221800.
- Then LW rs=4 rt=5 imm=0x0010 -> addr 1, wdata 0x10850010.
- count SHALL be 2.
REQ-031 JAL then done:
- JAL imm=0x40 with in_last=1 -> wdata 0x0C000040.
- done=1 for one cycle after the write; count=0.
- The next word SHALL be written to addr 0.
REQ-032 Illegal op: in_op=12 -> err=1 sticky, no mem_we, count unchanged; a subsequent SLT with all fields 0 SHALL give wdata 0x00000004.
REQ-033 Overflow: 64 back-to-back legal ops with in_last=0 -> addrs 0..63 written, then FULL with in_ready=0 and count=64; a 65th in_valid SHALL be ignored.
REQ-034 Edge cases and reset:
- Last-at-full: 64th op with in_last=1 -> done pulses, return to ACCEPT, no FULL.
- Reset asserted in the WRITE cycle -> mem_we=0 on the next cycle, wr_ptr=0, err=0.
